// File: rtl/multiply2_if.sv
// multiply2_if: operand/result bundle for the multiply2 2x2 matrix multiplier.
//
// Handshake: the master holds start high (level-sensitive) with mat_A/mat_B
// valid at the same edge; the slave accepts on the first such edge while idle.
// done rises together with a fresh mat_C and stays high while start remains
// high. Dropping start returns the slave to idle at the next edge. The
// operands only need to be valid at the accept edge.
//
// Signals:
//   start  master -> slave  operation request (level)
//   mat_A  master -> slave  operand A [row][col]
//   mat_B  master -> slave  operand B [row][col]
//   mat_C  slave -> master  registered result [row][col]
//   done   slave -> master  registered completion flag
interface multiply2_if #(
  parameter int DW = 8
);
  logic                        start;
  logic [1:0][1:0][DW-1:0]     mat_A;
  logic [1:0][1:0][DW-1:0]     mat_B;
  logic [1:0][1:0][DW-1:0]     mat_C;
  logic                        done;

  modport master (output start, output mat_A, output mat_B,
                  input  mat_C, input  done);
  modport slave  (input  start, input  mat_A, input  mat_B,
                  output mat_C, output done);
endinterface

// File: rtl/multiply2.sv
// multiply2: sequential 2x2 unsigned matrix multiplier, C = A x B.
// A single multiply-accumulate unit is stepped over the 8 partial products.
// Each result element is truncated to DW bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over everything)
//   mm         multiply2_if.slave: start, mat_A, mat_B in; mat_C, done out
//   state_dbg  current FSM state (IDLE=0, COMPUTE=1, DONE=2)
module multiply2 #(
  parameter int DW = 8,
  parameter int N  = 2
) (
  input  logic        clk,
  input  logic        rst,
  multiply2_if.slave  mm,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  typedef logic [1:0][1:0][DW-1:0] mat_t;

  logic [1:0]      state;
  mat_t            a_lat;
  mat_t            b_lat;
  mat_t            res;
  mat_t            c_q;
  logic            done_q;
  logic [2*DW:0]   acc;
  logic [2:0]      step;

  // step[2:1] walks (i,j) through (0,0),(0,1),(1,0),(1,1); step[0] is k.
  logic            idx_i;
  logic            idx_j;
  logic            idx_k;
  logic [2*DW-1:0] prod;
  logic [2*DW:0]   sum;
  mat_t            res_next;

  always_comb begin
    idx_i    = step[2];
    idx_j    = step[1];
    idx_k    = step[0];
    prod     = {{DW{1'b0}}, a_lat[idx_i][idx_k]} * {{DW{1'b0}}, b_lat[idx_k][idx_j]};
    // k==0 starts a fresh dot product, so the old accumulator is dropped.
    sum      = (idx_k ? acc : '0) + {1'b0, prod};
    res_next = res;
    if (idx_k) begin
      res_next[idx_i][idx_j] = sum[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_lat  <= '0;
      b_lat  <= '0;
      res    <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
      acc    <= '0;
      step   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (mm.start) begin
            a_lat <= mm.mat_A;
            b_lat <= mm.mat_B;
            acc   <= '0;
            step  <= '0;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          acc <= sum;
          res <= res_next;
          if (step == 3'd7) begin
            // res_next already holds the final element, so mat_C updates
            // as a whole in one edge.
            c_q    <= res_next;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            step <= step + 3'd1;
          end
        end
        S_DONE: begin
          if (!mm.start) begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign mm.mat_C  = c_q;
  assign mm.done   = done_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_multiply2.sv
// tb_multiply2: directed testbench for multiply2 with hand-computed results.
module tb_multiply2;

  localparam int DW = 8;
  typedef logic [1:0][1:0][DW-1:0] mat_t;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  multiply2_if #(.DW(DW)) mm ();

  multiply2 #(.DW(DW), .N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mm        (mm),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mat_t mk(input logic [DW-1:0] m00, input logic [DW-1:0] m01,
                              input logic [DW-1:0] m10, input logic [DW-1:0] m11);
    mat_t m;
    m[0][0] = m00;
    m[0][1] = m01;
    m[1][0] = m10;
    m[1][1] = m11;
    return m;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        m[r][c] = DW'($urandom_range(0, 255));
    return m;
  endfunction

  // Checkers
  task automatic check_c(input string tag, input mat_t expected);
    checks++;
    assert (mm.mat_C === expected) else begin
      errors++;
      $error("FAIL %s: mat_C observed %h expected %h", tag, mm.mat_C, expected);
    end
  endtask

  task automatic check_done(input string tag, input logic expected);
    checks++;
    assert (mm.done === expected) else begin
      errors++;
      $error("FAIL %s: done observed %b expected %b", tag, mm.done, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] expected);
    checks++;
    assert (state_dbg === expected) else begin
      errors++;
      $error("FAIL %s: state observed %0d expected %0d", tag, state_dbg, expected);
    end
  endtask

  // Driver: full operation with start held through DONE. Inputs change on
  // negedges; outputs are sampled on negedges after each posedge.
  // prev_c is the result that must stay on mat_C during COMPUTE.
  task automatic run_op(input string tag, input mat_t a, input mat_t b,
                        input mat_t expected, input mat_t prev_c, input bit scramble);
    @(negedge clk);
    mm.mat_A = a;
    mm.mat_B = b;
    mm.start = 1'b1;
    @(negedge clk);                       // E0 has passed
    check_state({tag, "_accept"}, 2'd1);
    for (int n = 1; n <= 7; n++) begin
      if (scramble) begin
        mm.mat_A = rnd_mat();
        mm.mat_B = rnd_mat();
      end
      check_done({tag, "_busy"}, 1'b0);
      check_c({tag, "_hold"}, prev_c);
      @(negedge clk);                     // E(n) has passed
    end
    check_done({tag, "_busy7"}, 1'b0);
    @(negedge clk);                       // E8 has passed
    check_done({tag, "_done"}, 1'b1);
    check_c({tag, "_result"}, expected);
    @(negedge clk);                       // start still high
    check_done({tag, "_held"}, 1'b1);
    check_c({tag, "_stable"}, expected);
    mm.start = 1'b0;
    @(negedge clk);
    check_done({tag, "_release"}, 1'b0);
    check_state({tag, "_idle"}, 2'd0);
    check_c({tag, "_kept"}, expected);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    mm.start = 1'b1;
    mm.mat_A = rnd_mat();
    mm.mat_B = rnd_mat();

    // Reset for 2 cycles with start high: reset must win
    @(negedge clk);
    @(negedge clk);
    check_c("reset_c", '0);
    check_done("reset_done", 1'b0);
    check_state("reset_state", 2'd0);
    rst      = 1'b0;
    mm.start = 1'b0;

    // Idle with start low and wandering operands
    for (int n = 0; n < 10; n++) begin
      mm.mat_A = rnd_mat();
      mm.mat_B = rnd_mat();
      @(negedge clk);
      check_c("idle_c", '0);
      check_done("idle_done", 1'b0);
    end

    run_op("all2x4", mk(2, 2, 2, 2), mk(4, 4, 4, 4), mk(16, 16, 16, 16), '0, 1'b0);
    run_op("basic", mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(19, 22, 43, 50),
           mk(16, 16, 16, 16), 1'b0);
    run_op("ident", mk(1, 0, 0, 1), mk(9, 8, 7, 6), mk(9, 8, 7, 6),
           mk(19, 22, 43, 50), 1'b0);
    run_op("ovf255", mk(255, 255, 255, 255), mk(255, 255, 255, 255), mk(2, 2, 2, 2),
           mk(9, 8, 7, 6), 1'b0);
    run_op("wrap256", mk(16, 16, 0, 0), mk(8, 8, 8, 8), mk(0, 0, 0, 0),
           mk(2, 2, 2, 2), 1'b0);
    run_op("scramble", mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(19, 22, 43, 50),
           mk(0, 0, 0, 0), 1'b1);

    // Reset in the middle of a computation (step 4)
    @(negedge clk);
    mm.mat_A = mk(3, 1, 4, 1);
    mm.mat_B = mk(5, 9, 2, 6);
    mm.start = 1'b1;
    for (int n = 0; n < 5; n++) @(negedge clk);   // E0..E4 passed
    check_state("midrst_busy", 2'd1);
    rst = 1'b1;
    @(negedge clk);
    check_state("midrst_state", 2'd0);
    check_c("midrst_c", '0);
    check_done("midrst_done", 1'b0);
    rst      = 1'b0;
    mm.start = 1'b0;

    // A=[[3,1],[4,1]] B=[[5,9],[2,6]] -> [[17,33],[22,42]]
    run_op("after_rst", mk(3, 1, 4, 1), mk(5, 9, 2, 6), mk(17, 33, 22, 42), '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
